// File: rtl/cart_unlock_host_if.sv
// Console/cart pin bundle for the mapper unlock initiator.
// master is the host view; slave is the console-plus-cart environment view.
interface cart_unlock_host_if;
  logic        start;
  logic [7:0]  sys_addr;
  logic        sys_cen;
  logic        sys_ssn;
  logic        SO;
  logic        cart_rstn;
  logic [7:0]  ADDR;
  logic        CEn;
  logic        SSn;
  logic        busy;
  logic        done;
  logic        ok;
  logic [1:0]  err;
  logic [15:0] payload;

  modport master (
    input  start, sys_addr, sys_cen, sys_ssn, SO,
    output cart_rstn, ADDR, CEn, SSn, busy, done, ok, err, payload
  );

  modport slave (
    output start, sys_addr, sys_cen, sys_ssn, SO,
    input  cart_rstn, ADDR, CEn, SSn, busy, done, ok, err, payload
  );
endinterface

// File: rtl/cart_unlock_host.sv
// Cartridge mapper unlock initiator: pulses cart reset, presents 5A/A5 on ADDR,
// then captures a framed 16-bit serial response on SO and checks it.
module cart_unlock_host #(
  parameter int          RST_CYCLES = 4,
  parameter int          TIMEOUT    = 8,
  parameter logic [15:0] EXPECT     = 16'h28A0,
  parameter logic [7:0]  IDLE_ADDR  = 8'h00
) (
  input logic              CLK,
  input logic              RSTn,
  cart_unlock_host_if.master bus
);

  localparam int MAXC  = (RST_CYCLES > TIMEOUT) ? ((RST_CYCLES > 16) ? RST_CYCLES : 16)
                                                : ((TIMEOUT > 16) ? TIMEOUT : 16);
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RESET, S_GAP, S_ACK, S_NAK, S_START, S_DATA, S_STOP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               ok_q, ok_d;
  logic [1:0]         err_q, err_d;
  logic [15:0]        payload_q, payload_d;
  logic               busy;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 2'd0;
      payload_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      payload_q <= payload_d;
    end
  end

  // cnt_q is shared: reset length, start-bit timeout, then payload bit index.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    ok_d      = ok_q;
    err_d     = err_q;
    payload_d = payload_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_RESET;
          cnt_d     = '0;
          done_d    = 1'b0;
          ok_d      = 1'b0;
          err_d     = 2'd0;
          payload_d = 16'h0000;
        end
      end
      S_RESET: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: state_d = S_ACK;
      S_ACK: state_d = S_NAK;
      S_NAK: begin
        state_d = S_START;
        cnt_d   = '0;
      end
      S_START: begin
        if (!bus.SO) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        payload_d[cnt_q[3:0]] = bus.SO;
        if (cnt_q == CNT_W'(15)) begin
          state_d = S_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        // A bad stop bit outranks a payload mismatch.
        if (bus.SO) begin
          err_d = 2'd2;
        end else if (payload_q != EXPECT) begin
          err_d = 2'd3;
        end else begin
          ok_d  = 1'b1;
          err_d = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    bus.busy      = busy;
    bus.cart_rstn = (state_q != S_RESET);
    bus.CEn       = busy ? 1'b1 : bus.sys_cen;
    bus.SSn       = busy ? 1'b1 : bus.sys_ssn;
    bus.ADDR      = bus.sys_addr;
    if (busy) begin
      case (state_q)
        S_ACK:   bus.ADDR = 8'h5A;
        S_NAK:   bus.ADDR = 8'hA5;
        default: bus.ADDR = IDLE_ADDR;
      endcase
    end
  end

  assign bus.done    = done_q;
  assign bus.ok      = ok_q;
  assign bus.err     = err_q;
  assign bus.payload = payload_q;

endmodule

// File: doc/cart_unlock_host.md
Name: cart_unlock_host

Overview:
- Console-side initiator for the cartridge mapper unlock handshake.
- Pulses the cart's reset, then presents the address unlock sequence 8'h5A followed by 8'hA5 on the cart ADDR pins.
- Captures the cart's synchronous serial response on SO: start bit 0, 16-bit payload LSB first, stop bit 0.
- Reports whether the payload matches the expected word; a match means SYSTEM_CTRL1 bit 7 is set.
- When no sequence is running, console bus signals pass straight through to the cart pins.

Parameters:
- RST_CYCLES, 4: cycles cart_rstn is held low; legal range 1..255.
- TIMEOUT, 8: maximum cycles spent in START waiting for SO=0 before an error; must be at least 1.
- EXPECT, 16'h28A0: expected payload.
- IDLE_ADDR, 8'h00: ADDR value driven during RESET and GAP; must differ from 8'h5A and 8'hA5.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RSTn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to run the handshake.
- sys_addr  in  8  console ADDR, passed through when not busy.
- sys_cen  in  1  console CEn, passed through when not busy.
- sys_ssn  in  1  console SSn, passed through when not busy.
- SO  in  1  cart serial output, sampled directly on posedge CLK (no synchronizer).
- cart_rstn  out  1  drives the cart RSTn.
- ADDR  out  8  cart ADDR pins.
- CEn  out  1  cart CEn.
- SSn  out  1  cart SSn.
- busy  out  1  high while a sequence is in progress.
- done  out  1  level; set when a sequence ends.
- ok  out  1  valid when done=1; high means EXPECT was received with good framing.
- err  out  2  error code: 0 none, 1 start-bit timeout, 2 stop-bit error, 3 payload mismatch.
- payload  out  16  captured word.

Behaviour:
- Reset (RSTn=0 at a posedge):
  - State goes to IDLE; cart_rstn=1; busy=0, done=0, ok=0, err=0, payload=16'h0000.
  - Reset mid-sequence aborts immediately; nothing completes.
- Bus mux (combinational on state):
  - When busy=0: ADDR=sys_addr, CEn=sys_cen, SSn=sys_ssn.
  - When busy=1: CEn=1 and SSn=1; ADDR is set per state below.
- State machine, one transition per posedge:
  - IDLE or DONE: on start=1 → RESET. Clear done, ok, err, payload and the counter; busy=1 from the next cycle. start=0 → stay.
  - RESET: cart_rstn=0, ADDR=IDLE_ADDR, for exactly RST_CYCLES cycles → GAP.
  - GAP: one cycle, cart_rstn=1, ADDR=IDLE_ADDR → ACK.
  - ACK: one cycle, ADDR=8'h5A → NAK.
  - NAK: one cycle, ADDR=8'hA5 → START. The cart loads its shifter at the edge ending NAK.
  - START: ADDR=IDLE_ADDR.
    - SO=0 sampled → DATA with bit index 0. With a zero-latency cart this happens on the first START cycle.
    - SO=1 for TIMEOUT consecutive samples → DONE with err=1.
  - DATA: ADDR=IDLE_ADDR. Each cycle, payload[idx] <= SO and idx increments. After 16 samples (idx 0..15) → STOP.
  - STOP: one sample.
    - SO=1 → err=2.
    - SO=0 and payload≠EXPECT → err=3.
    - Otherwise ok=1, err=0.
    - Always → DONE. Framing error takes priority over mismatch.
  - DONE: done=1, busy=0, outputs held until the next start or reset.
- start is ignored while busy=1. A start asserted during the last cycle of STOP is also ignored.
- Timing: start sampled high at edge 0 puts ACK at cycle RST_CYCLES+2 after that edge.
- Total sequence length with a zero-latency cart: RST_CYCLES+1+2+1+16+1 cycles.
- SO is ignored outside START, DATA and STOP, including while the cart is in reset and SO is hi-Z.
- Counter widths must cover max(RST_CYCLES, TIMEOUT, 16) without wrap.
- A timeout counter reaching TIMEOUT saturates; there is no wrap-around.

Test Plan:
- Golden handshake: cart model emits 0, 16'h28A0 LSB first, 0, then idle 1s. Pulse start → ADDR shows 5A then A5 on consecutive cycles; done=1, ok=1, err=0, payload=16'h28A0. Cycle count from start = RST_CYCLES+21.
- Wrong payload: cart emits 16'h1234 with correct framing → done=1, ok=0, err=3, payload=16'h1234.
- Bad stop: cart emits 16'h28A0 but the stop bit is 1 → err=2, ok=0. Repeat with 16'h1234 and stop=1 → err=2 (framing priority).
- No response: SO held at 1 → exactly TIMEOUT START cycles, then done=1, err=1, payload=16'h0000.
- Pass-through and start handling:
  - When idle, sys_addr=8'hC2, sys_cen=0, sys_ssn=1 appear on ADDR/CEn/SSn.
  - During busy, CEn=SSn=1.
  - A start pulse during DATA has no effect.
  - A start after DONE reruns the sequence and clears done on the next cycle.
- Reset mid-operation: assert RSTn=0 for one edge during DATA idx 7 → next cycle is IDLE, cart_rstn=1, busy=0, done=0, payload=16'h0000, and ADDR follows sys_addr.
